// File: rtl/display_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment display blocks.
package display_pkg;

  localparam int NDIGITS_DEF  = 4;
  localparam int SCAN_DIV_DEF = 50000;
  localparam int BLANK_DEF    = 2;

  typedef logic [3:0] nibble_t;

  // Bit idx set when idx addresses one of the first n digits, otherwise all zero.
  function automatic logic [7:0] onehot(input int unsigned idx, input int unsigned n);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = (i == idx) && (i < n);
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running modulo-DIV counter with a terminal-count tick; shared by display and keypad scanners.
module scan_prescaler #(
  parameter int DIV = 50000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          tick,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed digit driver for decode7: staged ready/valid load, frame-aligned commit,
// leading-zero blanking and a registered num/decimal/one-hot digit-enable output.
module digit_scanner import display_pkg::*; #(
  parameter int NDIGITS  = NDIGITS_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int BLANK    = BLANK_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*NDIGITS-1:0] value,
  input  logic [NDIGITS-1:0]   dp,
  input  logic                 blank_lz,
  input  logic                 load,
  output logic                 ready,
  output logic [3:0]           num,
  output logic                 decimal,
  output logic [NDIGITS-1:0]   digit
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);

  logic                 tick;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 frame;
  logic                 pending;
  logic [4*NDIGITS-1:0] stage_val;
  logic [NDIGITS-1:0]   stage_dp;
  logic [4*NDIGITS-1:0] disp_val;
  logic [NDIGITS-1:0]   disp_dp;
  logic [NDIGITS-1:0]   blank_vec;
  nibble_t              sel_num;
  logic                 sel_dp;
  logic                 sel_blank;
  logic [NDIGITS-1:0]   digit_oh;
  nibble_t              num_p1;
  logic                 decimal_p1;
  logic [NDIGITS-1:0]   digit_p1;

  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .cnt   (cnt)
  );

  assign frame = tick && (idx == IDX_LAST);
  assign ready = !pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // A load landing on a frame boundary is only staged; it commits one frame later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      stage_val <= '0;
      stage_dp  <= '0;
      disp_val  <= '0;
      disp_dp   <= '0;
    end else begin
      if (load && ready) begin
        stage_val <= value;
        stage_dp  <= dp;
      end
      if (frame && pending) begin
        disp_val <= stage_val;
        disp_dp  <= stage_dp;
        pending  <= 1'b0;
      end else if (load && ready) begin
        pending <= 1'b1;
      end
    end
  end

  // Walk from the most-significant digit down, tracking whether everything above is zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_val[4*i +: 4] == 4'h0);
      blank_vec[i] = blank_lz && (i > 0) && zero_run && !disp_dp[i];
    end
  end

  always_comb begin
    sel_num   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_num   = disp_val[4*i +: 4];
        sel_dp    = disp_dp[i];
        sel_blank = blank_vec[i];
      end
    end
  end

  assign digit_oh = NDIGITS'(onehot(32'(idx), NDIGITS));

  // Output stage: one cycle behind cnt/idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_p1     <= '0;
      decimal_p1 <= 1'b0;
      digit_p1   <= '0;
    end else begin
      num_p1     <= sel_num;
      decimal_p1 <= sel_dp;
      digit_p1   <= (cnt >= BLANK_C && !sel_blank) ? digit_oh : '0;
    end
  end

  assign num     = num_p1;
  assign decimal = decimal_p1;
  assign digit   = digit_p1;

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner (NDIGITS=4, SCAN_DIV=4, BLANK=1): a cycle model pushes
// the expected output for each edge, and each scenario pops and compares after that edge.
module tb_digit_scanner;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        load;
  logic        ready;
  logic [3:0]  num;
  logic        decimal;
  logic [3:0]  digit;

  typedef struct packed {
    logic [3:0] num;
    logic       dec;
    logic [3:0] dig;
    logic       rdy;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;

  int          m_cnt;
  int          m_idx;
  logic        m_pend;
  logic [15:0] m_sval;
  logic [15:0] m_dval;
  logic [3:0]  m_sdp;
  logic [3:0]  m_ddp;

  always #5 clk = ~clk;

  digit_scanner #(.NDIGITS(ND), .SCAN_DIV(SD), .BLANK(BL)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .dp       (dp),
    .blank_lz (blank_lz),
    .load     (load),
    .ready    (ready),
    .num      (num),
    .decimal  (decimal),
    .digit    (digit)
  );

  function automatic logic m_blanked(input int i);
    if (!blank_lz || i == 0 || m_ddp[i]) return 1'b0;
    for (int j = i; j < ND; j++) begin
      if (m_dval[j*4 +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_pend = 1'b0;
    m_sval = '0;
    m_dval = '0;
    m_sdp  = '0;
    m_ddp  = '0;
    sb.delete();
  endtask

  // Predicts the outputs produced by the coming clock edge and pushes them.
  task automatic model_step();
    exp_t e;
    logic frm;
    e.num = m_dval[m_idx*4 +: 4];
    e.dec = m_ddp[m_idx];
    e.dig = (m_cnt >= BL && !m_blanked(m_idx)) ? 4'(1 << m_idx) : 4'b0000;
    frm = (m_cnt == SD - 1) && (m_idx == ND - 1);
    if (frm && m_pend) begin
      m_dval = m_sval;
      m_ddp  = m_sdp;
      m_pend = 1'b0;
    end else if (load && !m_pend) begin
      m_sval = value;
      m_sdp  = dp;
      m_pend = 1'b1;
    end
    if (m_cnt == SD - 1) begin
      m_cnt = 0;
      m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.rdy = !m_pend;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int hits, other;
    exp_t e;
    value = '0; dp = '0; blank_lz = 1'b1; load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (num !== 4'h0)     begin failures++; $display("FAIL reset_num got=%h want=0", num); end
    checks++; if (decimal !== 1'b0) begin failures++; $display("FAIL reset_decimal got=%b want=0", decimal); end
    checks++; if (digit !== 4'h0)   begin failures++; $display("FAIL reset_digit got=%b want=0000", digit); end
    checks++; if (ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hits = 0; other = 0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      model_step();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({num, decimal, digit, ready} !== e) begin
        failures++;
        $display("FAIL reset_scan cyc=%0d got num=%h dec=%b dig=%b rdy=%b want num=%h dec=%b dig=%b rdy=%b",
                 cyc, num, decimal, digit, ready, e.num, e.dec, e.dig, e.rdy);
      end
      if (digit === 4'b0001) hits++;
      else if (digit !== 4'b0000) other++;
    end
    checks++; if (hits !== 6)  begin failures++; $display("FAIL reset_pulse_count got=%0d want=6", hits); end
    checks++; if (other !== 0) begin failures++; $display("FAIL reset_other_digits got=%0d want=0", other); end
  endtask

  task automatic test_load_commit();
    logic [3:0] want[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_t e;
    int pc, pi;
    blank_lz = 1'b1;
    do_reset();
    value = 16'h1234; dp = 4'b0100;
    for (int cyc = 0; cyc < 32; cyc++) begin
      load = (cyc == 0);
      pc = m_cnt; pi = m_idx;
      model_step();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({num, decimal, digit, ready} !== e) begin
        failures++;
        $display("FAIL commit_scan cyc=%0d got num=%h dec=%b dig=%b rdy=%b want num=%h dec=%b dig=%b rdy=%b",
                 cyc, num, decimal, digit, ready, e.num, e.dec, e.dig, e.rdy);
      end
      if (cyc == 14) begin
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL commit_ready_held got=%b want=0", ready); end
      end
      if (cyc == 15) begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL commit_ready_back got=%b want=1", ready); end
      end
      if (cyc >= 16 && pc == 2) begin
        checks++;
        if (num !== want[pi] || decimal !== (pi == 2) || digit !== 4'(1 << pi)) begin
          failures++;
          $display("FAIL commit_slot%0d got num=%h dec=%b dig=%b want num=%h dec=%b dig=%b",
                   pi, num, decimal, digit, want[pi], (pi == 2), 4'(1 << pi));
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_load_pending();
    exp_t e;
    int nines, ones;
    blank_lz = 1'b1;
    do_reset();
    value = 16'h1234; dp = 4'b0000;
    nines = 0; ones = 0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (cyc == 4) value = 16'h9999;
      load = (cyc == 0 || cyc == 4);
      model_step();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({num, decimal, digit, ready} !== e) begin
        failures++;
        $display("FAIL pending_scan cyc=%0d got num=%h dec=%b dig=%b rdy=%b want num=%h dec=%b dig=%b rdy=%b",
                 cyc, num, decimal, digit, ready, e.num, e.dec, e.dig, e.rdy);
      end
      if (num === 4'h9) nines++;
      if (num === 4'h1 && digit === 4'b1000) ones++;
    end
    load = 1'b0;
    checks++; if (nines !== 0) begin failures++; $display("FAIL pending_nine_seen got=%0d want=0", nines); end
    checks++; if (ones !== 6)  begin failures++; $display("FAIL pending_msd_shown got=%0d want=6", ones); end
  endtask

  task automatic test_blanking();
    logic blz[3]        = '{1'b1, 1'b0, 1'b1};
    logic [3:0] dps[3]  = '{4'b0000, 4'b0000, 4'b1000};
    int exp_sh[3][4]    = '{'{3, 3, 0, 0}, '{3, 3, 3, 3}, '{3, 3, 0, 3}};
    exp_t e;
    int pi, bad;
    int shown[4];
    for (int k = 0; k < 3; k++) begin
      blank_lz = blz[k];
      do_reset();
      value = 16'h0042; dp = dps[k];
      shown = '{0, 0, 0, 0};
      bad = 0;
      for (int cyc = 0; cyc < 32; cyc++) begin
        load = (cyc == 0);
        pi = m_idx;
        model_step();
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({num, decimal, digit, ready} !== e) begin
          failures++;
          $display("FAIL blank%0d_scan cyc=%0d got num=%h dec=%b dig=%b rdy=%b want num=%h dec=%b dig=%b rdy=%b",
                   k, cyc, num, decimal, digit, ready, e.num, e.dec, e.dig, e.rdy);
        end
        if (cyc >= 16) begin
          if (digit !== 4'b0000) shown[pi]++;
          if (pi >= 2 && num !== 4'h0) bad++;
        end
      end
      load = 1'b0;
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (shown[s] !== exp_sh[k][s]) begin
          failures++;
          $display("FAIL blank%0d_slot%0d_enabled got=%0d want=%0d", k, s, shown[s], exp_sh[k][s]);
        end
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL blank%0d_upper_num got=%0d want=0", k, bad); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want[4] = '{4'h8, 4'h7, 4'h6, 4'h5};
    exp_t e;
    int pc, pi, early;
    blank_lz = 1'b1;
    do_reset();
    value = 16'h5678; dp = 4'b0000;
    early = 0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      load = (cyc == 15);
      pc = m_cnt; pi = m_idx;
      model_step();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({num, decimal, digit, ready} !== e) begin
        failures++;
        $display("FAIL boundary_scan cyc=%0d got num=%h dec=%b dig=%b rdy=%b want num=%h dec=%b dig=%b rdy=%b",
                 cyc, num, decimal, digit, ready, e.num, e.dec, e.dig, e.rdy);
      end
      if (cyc == 15) begin
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL boundary_staged got=%b want=0", ready); end
      end
      if (cyc == 31) begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL boundary_commit got=%b want=1", ready); end
      end
      if (cyc >= 16 && cyc < 32 && num !== 4'h0) early++;
      if (cyc >= 32 && pc == 2) begin
        checks++;
        if (num !== want[pi] || digit !== 4'(1 << pi)) begin
          failures++;
          $display("FAIL boundary_slot%0d got num=%h dig=%b want num=%h dig=%b",
                   pi, num, digit, want[pi], 4'(1 << pi));
        end
      end
    end
    load = 1'b0;
    checks++; if (early !== 0) begin failures++; $display("FAIL boundary_early_show got=%0d want=0", early); end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    int nz;
    blank_lz = 1'b1;
    do_reset();
    value = 16'h1234; dp = 4'b0000;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (cyc == 16) value = 16'h9999;
      load = (cyc == 0 || cyc == 16);
      model_step();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({num, decimal, digit, ready} !== e) begin
        failures++;
        $display("FAIL midreset_pre cyc=%0d got num=%h dec=%b dig=%b rdy=%b want num=%h dec=%b dig=%b rdy=%b",
                 cyc, num, decimal, digit, ready, e.num, e.dec, e.dig, e.rdy);
      end
    end
    load = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (num !== 4'h0)     begin failures++; $display("FAIL midreset_num got=%h want=0", num); end
    checks++; if (decimal !== 1'b0) begin failures++; $display("FAIL midreset_decimal got=%b want=0", decimal); end
    checks++; if (digit !== 4'h0)   begin failures++; $display("FAIL midreset_digit got=%b want=0000", digit); end
    checks++; if (ready !== 1'b1)   begin failures++; $display("FAIL midreset_ready got=%b want=1", ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nz = 0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      model_step();
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({num, decimal, digit, ready} !== e) begin
        failures++;
        $display("FAIL midreset_post cyc=%0d got num=%h dec=%b dig=%b rdy=%b want num=%h dec=%b dig=%b rdy=%b",
                 cyc, num, decimal, digit, ready, e.num, e.dec, e.dig, e.rdy);
      end
      if (cyc == 0) begin
        checks++; if (digit !== 4'b0000) begin failures++; $display("FAIL midreset_first_blank got=%b want=0000", digit); end
      end
      if (cyc == 1) begin
        checks++; if (digit !== 4'b0001) begin failures++; $display("FAIL midreset_slot0 got=%b want=0001", digit); end
      end
      if (num !== 4'h0) nz++;
    end
    checks++; if (nz !== 0) begin failures++; $display("FAIL midreset_value_lost got=%0d want=0", nz); end
  endtask

  initial begin
    reset = 1'b0; value = '0; dp = '0; blank_lz = 1'b1; load = 1'b0;
    model_reset();
    test_reset();
    test_load_commit();
    test_load_pending();
    test_blanking();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
